// File: rtl/bus_mem_arb_slave.sv
// Round-robin multi-master memory slave: one transaction in flight, programmable wait states, clear mode, error flag.
// Latency: gnt 1 edge after req, rdy WAIT_CYCLES+1 edges after start; backpressure: losers hold req until granted.
module bus_mem_arb_slave #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    req,
  input  logic [NUM_MASTERS-1:0]    start,
  input  logic [2*NUM_MASTERS-1:0]  mode,
  input  logic [AW*NUM_MASTERS-1:0] addr,
  input  logic [DW*NUM_MASTERS-1:0] wdata,
  output logic [NUM_MASTERS-1:0]    gnt,
  output logic [NUM_MASTERS-1:0]    rdy,
  output logic                      err,
  output logic [DW-1:0]             rdata
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_RD  = 2'b00;
  localparam logic [1:0] MODE_WR  = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RESP} state_t;

  typedef struct packed {
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          any_req;
  logic [CW-1:0] cnt;
  txn_t          txn;
  txn_t          sel_txn;
  logic          acc_ok;
  logic          last_busy;
  logic [MW-1:0] mem_idx;
  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    mode_a  [NUM_MASTERS];
  logic [AW-1:0] addr_a  [NUM_MASTERS];
  logic [DW-1:0] wdata_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    assign mode_a[i]  = mode[2*i +: 2];
    assign addr_a[i]  = addr[AW*i +: AW];
    assign wdata_a[i] = wdata[DW*i +: DW];
  end

  // Scan downwards so the nearest requester after rr_ptr is the last one assigned.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_txn.mode  = mode_a[owner];
    sel_txn.addr  = addr_a[owner];
    sel_txn.wdata = wdata_a[owner];
  end

  assign acc_ok    = (txn.mode != MODE_RSV) && (32'(txn.addr) < DEPTH);
  assign last_busy = (state == BUSY) && (cnt == '0);
  assign mem_idx   = txn.addr[MW-1:0];

  // Storage is deliberately not reset; reset only suppresses the pending access.
  always_ff @(posedge clk) begin
    if (!rst && last_busy && acc_ok && txn.mode != MODE_RD)
      mem[mem_idx] <= (txn.mode == MODE_WR) ? txn.wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      rdy    <= '0;
      err    <= 1'b0;
      rdata  <= '0;
      rr_ptr <= PW'(NUM_MASTERS - 1);
      owner  <= '0;
      cnt    <= '0;
      txn    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt         <= '0;
            gnt[winner] <= 1'b1;
            owner       <= winner;
            state       <= GRANTED;
          end
        end
        GRANTED: begin
          if (start[owner]) begin
            txn   <= sel_txn;
            cnt   <= CW'(WAIT_CYCLES);
            state <= BUSY;
          end else if (!req[owner]) begin
            gnt    <= '0;
            rr_ptr <= owner;
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rdy   <= gnt;
            err   <= !acc_ok;
            state <= RESP;
            if (acc_ok && txn.mode == MODE_RD)
              rdata <= mem[mem_idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          gnt    <= '0;
          rdy    <= '0;
          err    <= 1'b0;
          rr_ptr <= owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_arb_slave.sv
// Scoreboard bench: dut_a (DEPTH 256, 1 wait state) and dut_b (DEPTH 128, no wait state).
module tb_bus_mem_arb_slave;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, CLR = 2'b10, RSV = 2'b11;

  typedef struct packed {
    logic [1:0] rdy;
    logic       err;
    logic       chk;
    logic [7:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [1:0]  req   [2];
  logic [1:0]  start [2];
  logic [3:0]  mode  [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  gnt   [2];
  logic [1:0]  rdy   [2];
  logic        err   [2];
  logic [7:0]  rdata [2];

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  bus_mem_arb_slave #(.NUM_MASTERS(2), .DW(8), .AW(8), .DEPTH(256), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst[0]), .req(req[0]), .start(start[0]), .mode(mode[0]), .addr(addr[0]),
    .wdata(wdata[0]), .gnt(gnt[0]), .rdy(rdy[0]), .err(err[0]), .rdata(rdata[0]));

  bus_mem_arb_slave #(.NUM_MASTERS(2), .DW(8), .AW(8), .DEPTH(128), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst[1]), .req(req[1]), .start(start[1]), .mode(mode[1]), .addr(addr[1]),
    .wdata(wdata[1]), .gnt(gnt[1]), .rdy(rdy[1]), .err(err[1]), .rdata(rdata[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rdy pulse pops one expectation for that DUT.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   got;
      got = 1'b0;
      e   = '0;
      if (rdy[d] !== 2'b00) begin
        if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
        if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
        if (!got) begin
          check($sformatf("unexpected_rdy_d%0d", d), 32'(rdy[d]), 32'd0);
        end else begin
          check($sformatf("rdy_d%0d", d), 32'(rdy[d]), 32'(e.rdy));
          check($sformatf("err_d%0d", d), 32'(err[d]), 32'(e.err));
          if (e.chk) check($sformatf("rdata_d%0d", d), 32'(rdata[d]), 32'(e.rdata));
        end
      end
      if (rst[d] === 1'b0 && gnt[d] === 2'b11)
        check($sformatf("gnt_onehot_d%0d", d), 32'(gnt[d]), 32'd1);
    end
  end

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
  endtask

  // Uncontended transaction from an idle DUT; caller is #1 after a rising edge.
  task automatic txn(input int d, input int m, input logic [1:0] md, input logic [7:0] a,
                     input logic [7:0] wd, input logic e_err, input logic e_chk, input logic [7:0] e_rd);
    exp_t e;
    int   n;
    e.rdy   = 2'(2'b01 << m);
    e.err   = e_err;
    e.chk   = e_chk;
    e.rdata = e_rd;
    mode[d][2*m +: 2]  = md;
    addr[d][8*m +: 8]  = a;
    wdata[d][8*m +: 8] = wd;
    req[d][m]          = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!gnt[d][m] && n < 20);
    check($sformatf("gnt_latency_d%0d_m%0d", d, m), 32'(n), 32'd1);
    push(d, e);
    start[d][m] = 1'b1;
    tick();
    start[d][m] = 1'b0;
    req[d][m]   = 1'b0;
    n = 0;
    while (!rdy[d][m] && n < 20) begin tick(); n++; end
    check($sformatf("rdy_latency_d%0d_m%0d", d, m), 32'(n), (d == 0) ? 32'd2 : 32'd1);
    tick();
    check($sformatf("gnt_release_d%0d", d), 32'(gnt[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = '0; start[d] = '0; mode[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_gnt_d%0d", d), 32'(gnt[d]), 32'd0);
      check($sformatf("reset_rdy_d%0d", d), 32'(rdy[d]), 32'd0);
      check($sformatf("reset_err_d%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("reset_rdata_d%0d", d), 32'(rdata[d]), 32'd0);
      rst[d] = 1'b0;
    end

    // Basic write then read-after-write.
    txn(0, 0, WR, 8'h12, 8'hA5, 1'b0, 1'b1, 8'h00);
    txn(0, 0, RD, 8'h12, 8'h00, 1'b0, 1'b1, 8'hA5);

    // Both masters request continuously from reset: grants alternate m0, m1, m0, m1.
    do_reset(0);
    mode[0] = {RD, RD};
    addr[0] = 16'h1212;
    req[0]  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (gnt[0] == 2'b00 && n < 20) begin tick(); n++; end
      check($sformatf("rr_grant_%0d", k), 32'(gnt[0]), 32'(2'b01 << (k % 2)));
      e = '{rdy: 2'(2'b01 << (k % 2)), err: 1'b0, chk: 1'b1, rdata: 8'hA5};
      push(0, e);
      start[0][k % 2] = 1'b1;
      tick();
      start[0] = 2'b00;
      n = 0;
      while (rdy[0] == 2'b00 && n < 20) begin tick(); n++; end
      tick();
      if (k == 3) req[0] = 2'b00;
    end

    // Reserved mode: error, memory and rdata untouched.
    txn(0, 1, WR,  8'h05, 8'h5A, 1'b0, 1'b1, 8'hA5);
    txn(0, 1, RSV, 8'h05, 8'hEE, 1'b1, 1'b1, 8'hA5);
    txn(0, 0, RD,  8'h05, 8'h00, 1'b0, 1'b1, 8'h5A);

    // Reset lands on the edge that would complete a write: nothing happens.
    txn(0, 0, WR, 8'h20, 8'h33, 1'b0, 1'b1, 8'h5A);
    mode[0][1:0] = WR; addr[0][7:0] = 8'h20; wdata[0][7:0] = 8'h77;
    req[0][0] = 1'b1;
    tick();
    start[0][0] = 1'b1;
    tick();
    start[0][0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    req[0] = 2'b00;
    tick();
    check("rst_busy_gnt", 32'(gnt[0]), 32'd0);
    check("rst_busy_rdy", 32'(rdy[0]), 32'd0);
    check("rst_busy_rdata", 32'(rdata[0]), 32'd0);
    rst[0] = 1'b0;
    tick();
    txn(0, 0, RD, 8'h20, 8'h00, 1'b0, 1'b1, 8'h33);

    // Abandon: m0 granted, drops req without start while m1 requests.
    do_reset(0);
    req[0][0] = 1'b1;
    tick();
    check("abandon_gnt0", 32'(gnt[0]), 32'h1);
    mode[0][3:2] = RD; addr[0][15:8] = 8'h05;
    req[0] = 2'b10;
    tick();
    check("abandon_drop", 32'(gnt[0]), 32'h0);
    tick();
    check("abandon_gnt1", 32'(gnt[0]), 32'h2);
    e = '{rdy: 2'b10, err: 1'b0, chk: 1'b1, rdata: 8'h5A};
    push(0, e);
    start[0][1] = 1'b1;
    tick();
    start[0] = 2'b00;
    req[0]   = 2'b00;
    n = 0;
    while (!rdy[0][1] && n < 20) begin tick(); n++; end
    check("abandon_rdy_latency", 32'(n), 32'd1 + 32'd1);
    tick();

    // DEPTH 128, no wait states: bounds, clear and 1-edge latency.
    txn(1, 0, WR,  8'hF0, 8'h11, 1'b1, 1'b1, 8'h00);
    txn(1, 0, RD,  8'hF0, 8'h00, 1'b1, 1'b1, 8'h00);
    txn(1, 0, WR,  8'h10, 8'h3C, 1'b0, 1'b1, 8'h00);
    txn(1, 0, RD,  8'h10, 8'h00, 1'b0, 1'b1, 8'h3C);
    txn(1, 0, CLR, 8'h10, 8'hFF, 1'b0, 1'b1, 8'h3C);
    txn(1, 0, RD,  8'h10, 8'h00, 1'b0, 1'b1, 8'h00);
    txn(1, 1, WR,  8'h7F, 8'hC3, 1'b0, 1'b1, 8'h00);
    txn(1, 1, RD,  8'h7F, 8'h00, 1'b0, 1'b1, 8'hC3);
    txn(1, 1, RD,  8'h80, 8'h00, 1'b1, 1'b1, 8'hC3);

    tick();
    tick();
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
